// File: rtl/psram_pkg.sv
// Shared types and constants for the burst-mode pseudo-SRAM model.
// Covers the FSM states, burst-length codes and config-register field layout.
package psram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RD   = 2'd2,
      ST_WR   = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      BL_4    = 2'd0,
      BL_8    = 2'd1,
      BL_16   = 2'd2,
      BL_CONT = 2'd3
   } bl_code_e;

   localparam int CFG_BL_LSB   = 0;
   localparam int CFG_BL_MSB   = 1;
   localparam int CFG_WRAP_BIT = 2;
   localparam int CFG_LAT_LSB  = 3;
   localparam int CFG_LAT_MSB  = 6;

   localparam logic [3:0] LAT_MIN = 4'd2;
   localparam logic [3:0] LAT_MAX = 4'd15;

   typedef struct packed {
      logic [3:0] lat;
      bl_code_e   bl;
      logic       wrap;
   } cfg_t;

   // Beat count of a fixed burst; continuous bursts report 0.
   function automatic logic [4:0] bl_beats(input bl_code_e code);
      case (code)
         BL_4:    return 5'd4;
         BL_8:    return 5'd8;
         BL_16:   return 5'd16;
         default: return 5'd0;
      endcase
   endfunction

   function automatic cfg_t cfg_from_addr(input logic [6:0] value);
      cfg_t       cfg;
      logic [3:0] lat;
      lat      = value[CFG_LAT_MSB:CFG_LAT_LSB];
      cfg.lat  = (lat < LAT_MIN) ? LAT_MIN : ((lat > LAT_MAX) ? LAT_MAX : lat);
      cfg.bl   = bl_code_e'(value[CFG_BL_MSB:CFG_BL_LSB]);
      cfg.wrap = value[CFG_WRAP_BIT];
      return cfg;
   endfunction

endpackage

// File: rtl/psram_if.sv
// Control/address side of the pseudo-SRAM bus; the data bus stays a plain inout.
interface psram_if #(
   parameter int A_WIDTH = 16
);
   logic [A_WIDTH-1:0] addr;
   logic               adv_L;
   logic               ce_L;
   logic               oe_L;
   logic               we_L;
   logic               ub_L;
   logic               lb_L;
   logic               mcre;
   logic               mem_wait;

   modport master (
      output addr, adv_L, ce_L, oe_L, we_L, ub_L, lb_L, mcre,
      input  mem_wait
   );

   modport slave (
      input  addr, adv_L, ce_L, oe_L, we_L, ub_L, lb_L, mcre,
      output mem_wait
   );
endinterface

// File: rtl/psram_burst_addr_gen.sv
// Burst address counter (wrap or linear) plus beat counter with last-beat flag.
module psram_burst_addr_gen
   import psram_pkg::*;
#(
   parameter  int DEPTH = 256,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_L,
   input  logic          i_load,
   input  logic [AW-1:0] i_addr,
   input  logic          i_wrap,
   input  bl_code_e      i_bl,
   input  logic          i_step,
   output logic [AW-1:0] o_addr,
   output logic          o_last_beat
);

   logic [AW-1:0] r_addr;
   logic [4:0]    r_cnt;
   logic          r_wrap;
   bl_code_e      r_bl;

   logic [AW-1:0] w_mask;
   logic [AW-1:0] w_inc;
   logic [AW-1:0] w_next;

   // Wrap mode keeps the upper bits and lets only the low log2(BL) bits roll over.
   assign w_mask = AW'(bl_beats(r_bl) - 5'd1);
   assign w_inc  = r_addr + AW'(1);
   assign w_next = (r_wrap && (r_bl != BL_CONT)) ? ((r_addr & ~w_mask) | (w_inc & w_mask))
                                                  : w_inc;

   assign o_addr      = r_addr;
   assign o_last_beat = (r_bl != BL_CONT) && (r_cnt == (bl_beats(r_bl) - 5'd1));

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         r_addr <= '0;
         r_cnt  <= '0;
         r_wrap <= 1'b0;
         r_bl   <= BL_4;
      end else if (i_load) begin
         r_addr <= i_addr;
         r_cnt  <= '0;
         r_wrap <= i_wrap;
         r_bl   <= i_bl;
      end else if (i_step) begin
         r_addr <= w_next;
         r_cnt  <= r_cnt + 5'd1;
      end
   end

endmodule

// File: rtl/psram_burst_model.sv
// Behavioural pseudo-SRAM in synchronous burst mode: config register, latency,
// wrap/linear bursts and byte-lane writes on a tri-stated data bus.
module psram_burst_model
   import psram_pkg::*;
#(
   parameter int D_WIDTH      = 16,
   parameter int A_WIDTH      = 16,
   parameter int DEPTH        = 256,
   parameter int LAT_DEFAULT  = 4,
   parameter int BL_DEFAULT   = 0,
   parameter int WRAP_DEFAULT = 1
) (
   input  logic               clk,
   input  logic               rst_L,
   psram_if.slave             bus,
   inout  wire  [D_WIDTH-1:0] data
);

   localparam int   AW        = $clog2(DEPTH);
   localparam int   HALF      = D_WIDTH / 2;
   localparam cfg_t CFG_RESET = '{lat:  4'(LAT_DEFAULT),
                                  bl:   bl_code_e'(2'(BL_DEFAULT)),
                                  wrap: 1'(WRAP_DEFAULT)};

   state_e             r_state;
   cfg_t               r_cfg;
   logic [3:0]         r_lat_cnt;
   logic               r_is_wr;
   logic [D_WIDTH-1:0] r_mem [DEPTH];

   logic [A_WIDTH-1:0] w_addr;
   logic               w_unused_addr;
   logic               w_cfg_edge;
   logic               w_access_edge;
   logic               w_beat;
   logic               w_drive;
   logic               w_last;
   logic [AW-1:0]      w_cur;

   assign w_addr        = bus.addr;
   assign w_unused_addr = ^w_addr;

   assign w_cfg_edge    = (r_state == ST_IDLE) && !bus.ce_L && !bus.adv_L && bus.mcre && !bus.we_L;
   assign w_access_edge = (r_state == ST_IDLE) && !bus.ce_L && !bus.adv_L && !bus.mcre;
   assign w_beat        = ((r_state == ST_RD) || (r_state == ST_WR)) && !bus.ce_L;
   assign w_drive       = (r_state == ST_RD) && !bus.ce_L && !bus.oe_L;

   // ce_L gates both outputs directly so they release without waiting for an edge.
   assign bus.mem_wait  = (r_state == ST_WAIT) && !bus.ce_L;
   assign data          = w_drive ? r_mem[w_cur] : {D_WIDTH{1'bz}};

   psram_burst_addr_gen #(
      .DEPTH (DEPTH)
   ) u_addr_gen (
      .clk         (clk),
      .rst_L       (rst_L),
      .i_load      (w_access_edge),
      .i_addr      (w_addr[AW-1:0]),
      .i_wrap      (r_cfg.wrap),
      .i_bl        (r_cfg.bl),
      .i_step      (w_beat),
      .o_addr      (w_cur),
      .o_last_beat (w_last)
   );

   // NOTE: every register here uses <= so all branches see pre-edge values.
   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         r_state   <= ST_IDLE;
         r_cfg     <= CFG_RESET;
         r_lat_cnt <= '0;
         r_is_wr   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_cfg_edge) begin
                  r_cfg <= cfg_from_addr(w_addr[6:0]);
               end else if (w_access_edge) begin
                  r_is_wr   <= !bus.we_L;
                  r_lat_cnt <= r_cfg.lat - 4'd2;
                  r_state   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (bus.ce_L)            r_state   <= ST_IDLE;
               else if (r_lat_cnt == 0) r_state   <= r_is_wr ? ST_WR : ST_RD;
               else                     r_lat_cnt <= r_lat_cnt - 4'd1;
            end
            ST_RD, ST_WR: begin
               if (bus.ce_L || w_last) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // NOTE: the array is deliberately outside the reset so a reset never wipes contents.
   always_ff @(posedge clk) begin
      if ((r_state == ST_WR) && w_beat) begin
         if (!bus.ub_L) r_mem[w_cur][D_WIDTH-1:HALF] <= data[D_WIDTH-1:HALF];
         if (!bus.lb_L) r_mem[w_cur][HALF-1:0]       <= data[HALF-1:0];
      end
   end

endmodule
